// File: rtl/map_table_access_ctrl.sv
// -----------------------------------------------------------------------------
// map_table_access_ctrl
//
// Purpose:
//   Arbitrates the single-port 32 x 131 packet map table RAM between the
//   lookup engine and the host configuration port.
//
//   The lookup engine issues back-to-back reads and cannot be stalled
//   mid-burst. It is therefore gated by o_lookup_ready before a burst starts.
//   While a burst runs, its strobe and address pass straight through to the
//   RAM with no added latency.
//
//   Configuration accesses are single read/write requests. They are held
//   until a one-cycle ack, and they are serialised through a small FSM.
//   Every ack is followed by one GUARD cycle in which config requests are
//   ignored. This guarantees that the lookup engine always gets a window to
//   start, even under back-to-back config traffic.
//
// Optional feature (macro MAP_TABLE_INIT_CLEAR_EN):
//   When defined, the table is cleared after reset. Zero is written to
//   addresses 0..31 over 32 consecutive cycles, and o_init_done rises on the
//   33rd cycle after reset release.
//   When undefined, the controller starts in IDLE_S, o_init_done is 1 from
//   reset, and RAM contents are left untouched.
//
// Ports:
//   i_clk, i_rst        clock; asynchronous active-high reset
//   o_lookup_ready      lookup may start/continue issuing reads (combinational)
//   i_lookup_rd         lookup read strobe
//   iv_lookup_raddr     lookup read address
//   ov_lookup_rdata     RAM read data passed through to the lookup engine
//   i_cfg_req           config request, held until o_cfg_ack
//   i_cfg_wr            1 = write, 0 = read (valid with i_cfg_req)
//   iv_cfg_addr         config address
//   iv_cfg_wdata        config write data
//   o_cfg_ack           one-cycle completion pulse
//   ov_cfg_rdata        config read result (valid with ack, held until next read)
//   o_ram_rd, o_ram_wr  RAM strobes
//   ov_ram_addr         RAM address
//   ov_ram_wdata        RAM write data
//   iv_ram_rdata        RAM read data, valid two cycles after o_ram_rd
//   o_init_done         table is usable
//   o_rd_err            sticky: lookup read seen while o_lookup_ready was low
// -----------------------------------------------------------------------------
module map_table_access_ctrl (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic         o_lookup_ready,
  input  logic         i_lookup_rd,
  input  logic [4:0]   iv_lookup_raddr,
  output logic [130:0] ov_lookup_rdata,
  input  logic         i_cfg_req,
  input  logic         i_cfg_wr,
  input  logic [4:0]   iv_cfg_addr,
  input  logic [130:0] iv_cfg_wdata,
  output logic         o_cfg_ack,
  output logic [130:0] ov_cfg_rdata,
  output logic         o_ram_rd,
  output logic         o_ram_wr,
  output logic [4:0]   ov_ram_addr,
  output logic [130:0] ov_ram_wdata,
  input  logic [130:0] iv_ram_rdata,
  output logic         o_init_done,
  output logic         o_rd_err
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 131;

  typedef enum logic [2:0] {
    INIT_S    = 3'd0,
    IDLE_S    = 3'd1,
    LOOKUP_S  = 3'd2,
    CFG_WR_S  = 3'd3,
    CFG_RD_S  = 3'd4,
    CFG_ACK_S = 3'd5,
    GUARD_S   = 3'd6
  } state_e;

`ifdef MAP_TABLE_INIT_CLEAR_EN
  localparam state_e RST_STATE     = INIT_S;
  localparam logic   INIT_DONE_RST = 1'b0;
`else
  localparam state_e RST_STATE     = IDLE_S;
  localparam logic   INIT_DONE_RST = 1'b1;
`endif

  // FSM state and registered outputs
  state_e              state_q,       state_d;
  logic                ram_wr_q,      ram_wr_d;     // config / init write strobe
  logic                ram_rd_q,      ram_rd_d;     // config read strobe
  logic [ADDR_W-1:0]   ram_addr_q,    ram_addr_d;   // latched config / init address
  logic [DATA_W-1:0]   ram_wdata_q,   ram_wdata_d;  // latched config / init data
  logic                cfg_ack_q,     cfg_ack_d;
  logic [DATA_W-1:0]   cfg_rdata_q,   cfg_rdata_d;
  logic [1:0]          rd_cnt_q,      rd_cnt_d;     // config read latency counter
  logic                init_done_q,   init_done_d;
  logic                rd_err_q,      rd_err_d;
`ifdef MAP_TABLE_INIT_CLEAR_EN
  logic [ADDR_W:0]     init_cnt_q,    init_cnt_d;   // MSB set once all entries are cleared
`endif

  // Combinational helpers
  logic lookup_ready_s;
  logic lookup_grant_s;
  logic rd_viol_s;
  logic cfg_drive_s;

  // Ready: open in IDLE only while no config request is pending, always
  // open in LOOKUP (burst in progress) and GUARD (anti-starvation window).
  always_comb begin
    lookup_ready_s = 1'b0;
    case (state_q)
      IDLE_S:            lookup_ready_s = ~i_cfg_req;
      LOOKUP_S, GUARD_S: lookup_ready_s = 1'b1;
      default:           lookup_ready_s = 1'b0;
    endcase
  end

  assign lookup_grant_s = i_lookup_rd & lookup_ready_s;
  assign rd_viol_s      = i_lookup_rd & ~lookup_ready_s;
  // The registered config/init strobes own the RAM address bus while active.
  assign cfg_drive_s    = ram_wr_q | ram_rd_q;

  assign o_lookup_ready  = lookup_ready_s;
  assign o_ram_rd        = lookup_grant_s | ram_rd_q;
  assign o_ram_wr        = ram_wr_q;
  assign ov_ram_addr     = cfg_drive_s ? ram_addr_q : iv_lookup_raddr;
  assign ov_ram_wdata    = ram_wdata_q;
  assign ov_lookup_rdata = iv_ram_rdata;
  assign o_cfg_ack       = cfg_ack_q;
  assign ov_cfg_rdata    = cfg_rdata_q;
  assign o_init_done     = init_done_q;
  assign o_rd_err        = rd_err_q;

  // Next-state and next-output logic for the access FSM
  always_comb begin
    state_d     = state_q;
    ram_wr_d    = 1'b0;
    ram_rd_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cfg_ack_d   = 1'b0;
    cfg_rdata_d = cfg_rdata_q;
    rd_cnt_d    = rd_cnt_q;
    init_done_d = init_done_q;
    rd_err_d    = rd_err_q | rd_viol_s;
`ifdef MAP_TABLE_INIT_CLEAR_EN
    init_cnt_d  = init_cnt_q;
`endif

    case (state_q)
      INIT_S: begin
`ifdef MAP_TABLE_INIT_CLEAR_EN
        if (init_cnt_q[ADDR_W] == 1'b0) begin
          ram_wr_d    = 1'b1;
          ram_addr_d  = init_cnt_q[ADDR_W-1:0];
          ram_wdata_d = {DATA_W{1'b0}};
          init_cnt_d  = init_cnt_q + 6'd1;
        end else begin
          state_d     = IDLE_S;
          init_done_d = 1'b1;
        end
`else
        state_d     = IDLE_S;
        init_done_d = 1'b1;
`endif
      end

      IDLE_S: begin
        if (lookup_grant_s) begin
          state_d = LOOKUP_S;
        end else if (i_cfg_req) begin
          ram_addr_d = iv_cfg_addr;
          rd_cnt_d   = 2'd0;
          if (i_cfg_wr) begin
            state_d     = CFG_WR_S;
            ram_wr_d    = 1'b1;
            ram_wdata_d = iv_cfg_wdata;
          end else begin
            state_d  = CFG_RD_S;
            ram_rd_d = 1'b1;
          end
        end else begin
          state_d = IDLE_S;
        end
      end

      LOOKUP_S: begin
        if (i_lookup_rd) begin
          state_d = LOOKUP_S;
        end else begin
          state_d = IDLE_S;
        end
      end

      CFG_WR_S: begin
        state_d   = CFG_ACK_S;
        cfg_ack_d = 1'b1;
      end

      // The read strobe was issued on the first cycle in this state; the
      // RAM data arrives two cycles later, i.e. on the third cycle here.
      CFG_RD_S: begin
        if (rd_cnt_q == 2'd2) begin
          cfg_rdata_d = iv_ram_rdata;
          cfg_ack_d   = 1'b1;
          state_d     = CFG_ACK_S;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end

      CFG_ACK_S: begin
        state_d = GUARD_S;
      end

      GUARD_S: begin
        if (lookup_grant_s) begin
          state_d = LOOKUP_S;
        end else begin
          state_d = IDLE_S;
        end
      end

      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight config access
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= RST_STATE;
      ram_wr_q    <= 1'b0;
      ram_rd_q    <= 1'b0;
      ram_addr_q  <= {ADDR_W{1'b0}};
      ram_wdata_q <= {DATA_W{1'b0}};
      cfg_ack_q   <= 1'b0;
      cfg_rdata_q <= {DATA_W{1'b0}};
      rd_cnt_q    <= 2'd0;
      init_done_q <= INIT_DONE_RST;
      rd_err_q    <= 1'b0;
`ifdef MAP_TABLE_INIT_CLEAR_EN
      init_cnt_q  <= {(ADDR_W+1){1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      ram_wr_q    <= ram_wr_d;
      ram_rd_q    <= ram_rd_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cfg_ack_q   <= cfg_ack_d;
      cfg_rdata_q <= cfg_rdata_d;
      rd_cnt_q    <= rd_cnt_d;
      init_done_q <= init_done_d;
      rd_err_q    <= rd_err_d;
`ifdef MAP_TABLE_INIT_CLEAR_EN
      init_cnt_q  <= init_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_map_table_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_map_table_access_ctrl
//
// Self-checking bench for map_table_access_ctrl.
//
// A two-cycle-latency RAM model is attached to the RAM port. Expected table
// contents are kept in a separate shadow array that is updated only by the
// bench's own config writes. Cycle timing is predicted from the documented
// latencies.
//
// Inputs are driven 1 time unit after the rising edge, and outputs are
// sampled 1 time unit later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_map_table_access_ctrl;

  logic         clk = 1'b0;
  logic         i_rst;
  logic         o_lookup_ready;
  logic         i_lookup_rd;
  logic [4:0]   iv_lookup_raddr;
  logic [130:0] ov_lookup_rdata;
  logic         i_cfg_req;
  logic         i_cfg_wr;
  logic [4:0]   iv_cfg_addr;
  logic [130:0] iv_cfg_wdata;
  logic         o_cfg_ack;
  logic [130:0] ov_cfg_rdata;
  logic         o_ram_rd;
  logic         o_ram_wr;
  logic [4:0]   ov_ram_addr;
  logic [130:0] ov_ram_wdata;
  logic [130:0] ram_rdata;
  logic         o_init_done;
  logic         o_rd_err;

  int checks = 0;
  int errors = 0;

  logic [130:0] shadow  [32];   // expected table contents
  logic [130:0] ram_mem [32];   // RAM model storage
  logic [130:0] ram_s1;
  logic         load_go = 1'b0;

  always #5 clk = ~clk;

  map_table_access_ctrl dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .o_lookup_ready  (o_lookup_ready),
    .i_lookup_rd     (i_lookup_rd),
    .iv_lookup_raddr (iv_lookup_raddr),
    .ov_lookup_rdata (ov_lookup_rdata),
    .i_cfg_req       (i_cfg_req),
    .i_cfg_wr        (i_cfg_wr),
    .iv_cfg_addr     (iv_cfg_addr),
    .iv_cfg_wdata    (iv_cfg_wdata),
    .o_cfg_ack       (o_cfg_ack),
    .ov_cfg_rdata    (ov_cfg_rdata),
    .o_ram_rd        (o_ram_rd),
    .o_ram_wr        (o_ram_wr),
    .ov_ram_addr     (ov_ram_addr),
    .ov_ram_wdata    (ov_ram_wdata),
    .iv_ram_rdata    (ram_rdata),
    .o_init_done     (o_init_done),
    .o_rd_err        (o_rd_err)
  );

  // RAM model: synchronous write, read data two cycles after the strobe
  always @(posedge clk) begin
    if (load_go) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= shadow[i];
    end else if (o_ram_wr) begin
      ram_mem[ov_ram_addr] <= ov_ram_wdata;
    end
    ram_s1    <= o_ram_rd ? ram_mem[ov_ram_addr] : 131'd0;
    ram_rdata <= ram_s1;
  end

  function automatic logic [130:0] rand_data();
    logic [2:0] top;
    top = 3'($urandom_range(7, 0));
    return {top, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance to 1 unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_lookup_rd = 1'b0; iv_lookup_raddr = 5'd0;
    i_cfg_req = 1'b0; i_cfg_wr = 1'b0; iv_cfg_addr = 5'd0; iv_cfg_wdata = 131'd0;
  endtask

  // Reset sequence, including the table-clear phase when it is compiled in.
  // Returns 1 unit after the edge that opens an IDLE cycle.
  task automatic apply_reset();
    logic exp_done;
`ifdef MAP_TABLE_INIT_CLEAR_EN
    exp_done = 1'b0;
`else
    exp_done = 1'b1;
`endif
    i_rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    checks++; if (o_cfg_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", o_cfg_ack); end
    checks++; if (o_ram_wr !== 1'b0) begin errors++; $display("FAIL rst_ram_wr got %b want 0", o_ram_wr); end
    checks++; if (o_ram_rd !== 1'b0) begin errors++; $display("FAIL rst_ram_rd got %b want 0", o_ram_rd); end
    checks++; if (o_rd_err !== 1'b0) begin errors++; $display("FAIL rst_rd_err got %b want 0", o_rd_err); end
    checks++; if (ov_cfg_rdata !== 131'd0) begin errors++; $display("FAIL rst_cfg_rdata got %h want 0", ov_cfg_rdata); end
    checks++; if (ov_ram_wdata !== 131'd0) begin errors++; $display("FAIL rst_ram_wdata got %h want 0", ov_ram_wdata); end
    checks++; if (o_init_done !== exp_done) begin errors++; $display("FAIL rst_init_done got %b want %b", o_init_done, exp_done); end
    i_rst = 1'b0;
`ifdef MAP_TABLE_INIT_CLEAR_EN
    for (int k = 1; k <= 32; k++) begin
      cyc(); #1;
      checks++; if (o_ram_wr !== 1'b1 || ov_ram_addr !== 5'(k - 1) || ov_ram_wdata !== 131'd0)
        begin errors++; $display("FAIL init_write cycle %0d got wr=%b addr=%0d want wr=1 addr=%0d data=0", k, o_ram_wr, ov_ram_addr, k - 1); end
      checks++; if (o_init_done !== 1'b0 || o_lookup_ready !== 1'b0)
        begin errors++; $display("FAIL init_busy cycle %0d got done=%b ready=%b want 0 0", k, o_init_done, o_lookup_ready); end
    end
    for (int i = 0; i < 32; i++) shadow[i] = 131'd0;
`endif
    cyc(); #1;
    checks++; if (o_init_done !== 1'b1) begin errors++; $display("FAIL init_done got %b want 1", o_init_done); end
    checks++; if (o_ram_wr !== 1'b0 || o_lookup_ready !== 1'b1)
      begin errors++; $display("FAIL post_reset_idle got wr=%b ready=%b want 0 1", o_ram_wr, o_lookup_ready); end
    cyc();
  endtask

  // One config transaction starting in an IDLE cycle; checks strobes, ack
  // timing and read data. Returns at the start of the following IDLE cycle.
  task automatic cfg_xact(input logic wr, input logic [4:0] a, input logic [130:0] d);
    int lat;
    lat = wr ? 2 : 4;
    i_lookup_rd = 1'b0;
    i_cfg_req = 1'b1; i_cfg_wr = wr; iv_cfg_addr = a; iv_cfg_wdata = d;
    #1;
    checks++; if (o_lookup_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_low got %b want 0", o_lookup_ready); end
    for (int k = 1; k <= lat + 1; k++) begin
      cyc(); #1;
      checks++; if (o_ram_wr !== (wr && k == 1) || o_ram_rd !== (!wr && k == 1))
        begin errors++; $display("FAIL cfg_strobe T+%0d got wr=%b rd=%b want wr=%b rd=%b", k, o_ram_wr, o_ram_rd, wr && k == 1, !wr && k == 1); end
      if (k == 1) begin
        checks++; if (ov_ram_addr !== a || (wr && ov_ram_wdata !== d))
          begin errors++; $display("FAIL cfg_addr_data got addr=%0d data=%h want addr=%0d data=%h", ov_ram_addr, ov_ram_wdata, a, d); end
      end
      checks++; if (o_cfg_ack !== (k == lat))
        begin errors++; $display("FAIL cfg_ack T+%0d got %b want %b", k, o_cfg_ack, k == lat); end
      if (k == lat && !wr) begin
        checks++; if (ov_cfg_rdata !== shadow[a])
          begin errors++; $display("FAIL cfg_rdata addr %0d got %h want %h", a, ov_cfg_rdata, shadow[a]); end
      end
      if (k == lat) i_cfg_req = 1'b0;
      if (k == lat + 1) begin
        checks++; if (o_lookup_ready !== 1'b1) begin errors++; $display("FAIL guard_ready got %b want 1", o_lookup_ready); end
      end
    end
    if (wr) shadow[a] = d;
    cyc();
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_cfg_write_read();
    logic [130:0] pat;
    pat = {3'b010, 8'h5A, {14{8'h5A}}, 8'hA5};
    cfg_xact(1'b0, 5'd5, 131'd0);
    cfg_xact(1'b1, 5'd3, pat);
    cfg_xact(1'b0, 5'd3, 131'd0);
  endtask

  task automatic test_cfg_random();
    for (int n = 0; n < 16; n++) begin
      cfg_xact(1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), rand_data());
    end
  endtask

  task automatic test_lookup_passthrough();
    logic       h_rd   [40];
    logic [4:0] h_addr [40];
    logic       rd;
    logic [4:0] ad;
    for (int c = 0; c < 40; c++) begin
      if (c < 3) begin
        rd = 1'b1; ad = 5'(c);
      end else if (c < 37) begin
        rd = ($urandom_range(3, 0) != 0); ad = 5'($urandom_range(31, 0));
      end else begin
        rd = 1'b0; ad = 5'd0;
      end
      h_rd[c] = rd; h_addr[c] = ad;
      i_lookup_rd = rd; iv_lookup_raddr = ad;
      #1;
      checks++; if (o_lookup_ready !== 1'b1 || o_ram_wr !== 1'b0)
        begin errors++; $display("FAIL lk_ready cycle %0d got ready=%b wr=%b want 1 0", c, o_lookup_ready, o_ram_wr); end
      checks++; if (o_ram_rd !== rd || (rd && ov_ram_addr !== ad))
        begin errors++; $display("FAIL lk_strobe cycle %0d got rd=%b addr=%0d want rd=%b addr=%0d", c, o_ram_rd, ov_ram_addr, rd, ad); end
      if (c >= 2 && h_rd[c-2]) begin
        checks++; if (ov_lookup_rdata !== shadow[h_addr[c-2]])
          begin errors++; $display("FAIL lk_rdata cycle %0d got %h want %h", c, ov_lookup_rdata, shadow[h_addr[c-2]]); end
      end
      cyc();
    end
  endtask

  task automatic test_contention();
    logic [4:0]   a1, a2;
    logic [130:0] d1, d2;
    a1 = 5'($urandom_range(31, 0)); a2 = a1 ^ 5'd9;
    d1 = rand_data(); d2 = rand_data();
    // T: config request with the lookup engine waiting on ready
    i_cfg_req = 1'b1; i_cfg_wr = 1'b1; iv_cfg_addr = a1; iv_cfg_wdata = d1; i_lookup_rd = 1'b0;
    #1;
    checks++; if (o_lookup_ready !== 1'b0 || o_ram_rd !== 1'b0)
      begin errors++; $display("FAIL ct_cfg_first got ready=%b rd=%b want 0 0", o_lookup_ready, o_ram_rd); end
    cyc(); #1;
    checks++; if (o_ram_wr !== 1'b1 || ov_ram_addr !== a1) begin errors++; $display("FAIL ct_wr1 got wr=%b addr=%0d want 1 %0d", o_ram_wr, ov_ram_addr, a1); end
    cyc(); #1;
    checks++; if (o_cfg_ack !== 1'b1) begin errors++; $display("FAIL ct_ack1 got %b want 1", o_cfg_ack); end
    shadow[a1] = d1;
    // GUARD: second request arrives together with the lookup start
    cyc();
    iv_cfg_addr = a2; iv_cfg_wdata = d2;
    i_lookup_rd = 1'b1; iv_lookup_raddr = a1;
    #1;
    checks++; if (o_lookup_ready !== 1'b1 || o_ram_rd !== 1'b1 || o_ram_wr !== 1'b0)
      begin errors++; $display("FAIL ct_guard_start got ready=%b rd=%b wr=%b want 1 1 0", o_lookup_ready, o_ram_rd, o_ram_wr); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      i_lookup_rd = (k < 2);
      #1;
      checks++; if (o_lookup_ready !== 1'b1 || o_ram_wr !== 1'b0 || o_cfg_ack !== 1'b0)
        begin errors++; $display("FAIL ct_lookup_hold %0d got ready=%b wr=%b ack=%b want 1 0 0", k, o_lookup_ready, o_ram_wr, o_cfg_ack); end
    end
    // rd has fallen: back in IDLE, the pending request now wins
    cyc(); #1;
    checks++; if (o_lookup_ready !== 1'b0 || o_ram_wr !== 1'b0)
      begin errors++; $display("FAIL ct_idle_accept got ready=%b wr=%b want 0 0", o_lookup_ready, o_ram_wr); end
    cyc(); #1;
    checks++; if (o_ram_wr !== 1'b1 || ov_ram_addr !== a2 || ov_ram_wdata !== d2)
      begin errors++; $display("FAIL ct_wr2 got wr=%b addr=%0d want 1 %0d", o_ram_wr, ov_ram_addr, a2); end
    cyc(); #1;
    checks++; if (o_cfg_ack !== 1'b1) begin errors++; $display("FAIL ct_ack2 got %b want 1", o_cfg_ack); end
    i_cfg_req = 1'b0;
    shadow[a2] = d2;
    cyc(); cyc();
    checks++; if (o_rd_err !== 1'b0) begin errors++; $display("FAIL ct_no_err got %b want 0", o_rd_err); end
    cfg_xact(1'b0, a1, 131'd0);
    cfg_xact(1'b0, a2, 131'd0);
  endtask

  task automatic test_rd_err();
    logic [4:0] a;
    a = 5'($urandom_range(31, 0));
    #1;
    checks++; if (o_rd_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", o_rd_err); end
    i_cfg_req = 1'b1; i_cfg_wr = 1'b0; iv_cfg_addr = a;
    cyc();
    i_lookup_rd = 1'b1; iv_lookup_raddr = a ^ 5'd1;
    #1;
    checks++; if (o_ram_rd !== 1'b1 || ov_ram_addr !== a)
      begin errors++; $display("FAIL err_cfg_rd got rd=%b addr=%0d want 1 %0d", o_ram_rd, ov_ram_addr, a); end
    cyc(); #1;
    checks++; if (o_ram_rd !== 1'b0) begin errors++; $display("FAIL err_no_extra_rd got %b want 0", o_ram_rd); end
    checks++; if (o_rd_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", o_rd_err); end
    cyc();
    i_lookup_rd = 1'b0;
    #1;
    checks++; if (o_cfg_ack !== 1'b0) begin errors++; $display("FAIL err_early_ack got %b want 0", o_cfg_ack); end
    cyc(); #1;
    checks++; if (o_cfg_ack !== 1'b1 || ov_cfg_rdata !== shadow[a])
      begin errors++; $display("FAIL err_ack got ack=%b data=%h want 1 %h", o_cfg_ack, ov_cfg_rdata, shadow[a]); end
    i_cfg_req = 1'b0;
    repeat (4) cyc();
    checks++; if (o_rd_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", o_rd_err); end
  endtask

  task automatic test_reset_mid_write();
    logic [4:0]   a;
    logic [130:0] d;
    a = 5'($urandom_range(31, 0));
    d = ~shadow[a];
    i_cfg_req = 1'b1; i_cfg_wr = 1'b1; iv_cfg_addr = a; iv_cfg_wdata = d;
    cyc(); #1;
    checks++; if (o_ram_wr !== 1'b1) begin errors++; $display("FAIL mid_wr_active got %b want 1", o_ram_wr); end
    #1;
    i_rst = 1'b1;
    #1;
    checks++; if (o_ram_wr !== 1'b0 || o_cfg_ack !== 1'b0 || o_rd_err !== 1'b0)
      begin errors++; $display("FAIL mid_rst_outputs got wr=%b ack=%b err=%b want 0 0 0", o_ram_wr, o_cfg_ack, o_rd_err); end
    apply_reset();
    checks++; if (o_cfg_ack !== 1'b0) begin errors++; $display("FAIL mid_no_ack got %b want 0", o_cfg_ack); end
    cfg_xact(1'b0, a, 131'd0);
  endtask

  initial begin
    i_rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 32; i++) shadow[i] = rand_data();
    load_go = 1'b1;
    @(posedge clk); #1;
    load_go = 1'b0;
    test_reset();
    test_cfg_write_read();
    test_cfg_random();
    test_lookup_passthrough();
    test_contention();
    test_rd_err();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
